// File: rtl/encoder_8_to_3_stream.sv
// encoder_8_to_3_stream: accepts a multi-hot request vector over valid/ready
// and emits the index of every set bit, lowest first, one beat per handshake.
// An all-zero vector yields a single beat flagged with out_none.
module encoder_8_to_3_stream #(
  parameter int WIDTH = 8,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             out_none,
  output logic             busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   pending_q, pending_d;
  logic               zero_flag_q, zero_flag_d;

  logic [IDX_W-1:0]   lsb_idx;
  logic               lsb_found;
  logic               single_bit;
  logic [WIDTH-1:0]   pending_cleared;

  // Locate the lowest set bit of pending and derive the clear-lowest mask.
  always_comb begin
    lsb_idx   = '0;
    lsb_found = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (!lsb_found && pending_q[i]) begin
        lsb_idx   = IDX_W'(i);
        lsb_found = 1'b1;
      end
    end
    pending_cleared = pending_q & (pending_q - WIDTH'(1));
    single_bit      = (pending_q != '0) && (pending_cleared == '0);
  end

  // Beat outputs are purely a function of registered state, so they hold under stall.
  always_comb begin
    in_ready  = (state_q == IDLE) && !rst;
    out_valid = (state_q == DRAIN);
    busy      = (state_q == DRAIN);
    out_none  = out_valid && zero_flag_q;
    out_last  = out_valid && (zero_flag_q || single_bit);
    out_idx   = (out_valid && !zero_flag_q) ? lsb_idx : '0;
  end

  // Next-state: capture in IDLE, retire one bit per output handshake in DRAIN.
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    zero_flag_d = zero_flag_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          pending_d   = in;
          zero_flag_d = (in == '0);
          state_d     = DRAIN;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (zero_flag_q) begin
            zero_flag_d = 1'b0;
            state_d     = IDLE;
          end else begin
            pending_d = pending_cleared;
            if (out_last) state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      zero_flag_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      zero_flag_q <= zero_flag_d;
    end
  end

endmodule

// File: tb/tb_encoder_8_to_3_stream.sv
// Testbench for encoder_8_to_3_stream: directed and randomized vectors checked
// against a bit-scan reference model built from the vector value itself.
module tb_encoder_8_to_3_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_sig;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] out_idx;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       out_none;
  logic       busy;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [2:0] idx;
    logic       last;
    logic       none;
  } beat_t;

  encoder_8_to_3_stream #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in(in_sig), .in_valid(in_valid), .in_ready(in_ready),
    .out_idx(out_idx), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_none(out_none), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: list set-bit positions in ascending order; empty vector -> one none beat.
  function automatic void build_model(input logic [7:0] v, output beat_t q[$]);
    int cnt;
    int seen;
    beat_t b;
    q = {};
    cnt = 0;
    for (int i = 0; i < 8; i++) if (v[i]) cnt++;
    if (cnt == 0) begin
      b.idx = 3'd0; b.last = 1'b1; b.none = 1'b1;
      q.push_back(b);
    end else begin
      seen = 0;
      for (int i = 0; i < 8; i++) begin
        if (v[i]) begin
          seen++;
          b.idx = i[2:0]; b.last = (seen == cnt); b.none = 1'b0;
          q.push_back(b);
        end
      end
    end
  endfunction

  // Called between edges; returns just after the accepting posedge.
  task automatic accept(input logic [7:0] v);
    int n;
    in_sig   = v;
    in_valid = 1'b1;
    n = 0;
    while (1) begin
      #1;
      if (in_ready) break;
      @(negedge clk);
      n++;
      if (n > 50) begin
        chk("accept_timeout", 32'(n), 0);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // mode 0: ready always; 1: ready pattern 1,0,0; 2: random ready.
  task automatic drain(input logic [7:0] v, input int mode);
    beat_t q[$];
    beat_t e;
    logic [2:0] s_idx;
    logic s_last, s_none, stalled, rdy;
    int cyc;
    build_model(v, q);
    cyc = 0;
    stalled = 1'b0;
    s_idx = '0; s_last = 1'b0; s_none = 1'b0;
    while (q.size() > 0 && cyc < 200) begin
      @(negedge clk);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      #1;
      chk("drain_valid", out_valid, 1);
      chk("drain_busy", busy, 1);
      chk("drain_in_ready", in_ready, 0);
      if (stalled) begin
        chk("stall_idx", out_idx, s_idx);
        chk("stall_last", out_last, s_last);
        chk("stall_none", out_none, s_none);
      end
      if (out_valid && rdy) begin
        e = q.pop_front();
        chk("beat_idx", out_idx, e.idx);
        chk("beat_last", out_last, e.last);
        chk("beat_none", out_none, e.none);
        stalled = 1'b0;
      end else if (out_valid) begin
        stalled = 1'b1;
        s_idx = out_idx; s_last = out_last; s_none = out_none;
      end
      cyc++;
    end
    if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 0);
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    chk("idle_in_ready", in_ready, 1);
    chk("idle_busy", busy, 0);
    chk("idle_valid", out_valid, 0);
  endtask

  initial begin
    logic [7:0] v;
    rst = 1'b1; in_sig = '0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_last", out_last, 0);
    chk("rst_none", out_none, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // Directed vectors.
    accept(8'b0010_0101); drain(8'b0010_0101, 0);
    accept(8'b1000_0000); drain(8'b1000_0000, 0);
    accept(8'b0000_0001); drain(8'b0000_0001, 0);
    accept(8'h00);        drain(8'h00, 0);
    accept(8'hFF);        drain(8'hFF, 1);

    // Reset mid-drain: consume idx 5, then reset before idx 6 can be taken.
    accept(8'b0110_0000);
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("mid_first_idx", out_idx, 5);
    chk("mid_first_last", out_last, 0);
    @(negedge clk);
    out_ready = 1'b0;
    rst = 1'b1; in_valid = 1'b1; in_sig = 8'hFF;
    #1;
    chk("mid_rst_in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("mid_after_valid", out_valid, 0);
    chk("mid_after_busy", busy, 0);
    chk("mid_after_in_ready", in_ready, 1);

    // Reset and in_valid together while idle: vector must be dropped.
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; in_sig = 8'h03;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("rst_win_busy", busy, 0);
    chk("rst_win_valid", out_valid, 0);

    // New vector held during drain is ignored, then accepted once idle.
    accept(8'b0001_0010);
    in_sig = 8'b1100_0000; in_valid = 1'b1;
    drain(8'b0001_0010, 2);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain(8'b1100_0000, 0);

    // Randomized vectors with random backpressure.
    for (int n = 0; n < 40; n++) begin
      v = (n % 8 == 3) ? 8'h00 : 8'($urandom);
      accept(v);
      drain(v, (n % 3 == 0) ? 0 : 2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
